// File: rtl/quad_encoder_emulator_pkg.sv
// Shared constants for the quadrature encoder emulator: phase-to-AB map,
// FSM encoding and the minimum legal edge spacing.
package quad_pkg;

    // AB patterns for phase index 0..3 (A is bit 1, B is bit 0)
    localparam logic [1:0] QPH_00 = 2'b00;
    localparam logic [1:0] QPH_01 = 2'b01;
    localparam logic [1:0] QPH_11 = 2'b11;
    localparam logic [1:0] QPH_10 = 2'b10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    localparam int unsigned MIN_PERIOD = 2;

    function automatic logic [1:0] phase_to_ab(input logic [1:0] p);
        logic [1:0] ab;
        case (p)
            2'd0:    ab = QPH_00;
            2'd1:    ab = QPH_01;
            2'd2:    ab = QPH_11;
            default: ab = QPH_10;
        endcase
        return ab;
    endfunction

endpackage

// File: rtl/quad_encoder_emulator_if.sv
// Command/status bundle between a move requester and the encoder emulator.
interface quad_encoder_emulator_if #(
    parameter int unsigned DIV_W = 24,
    parameter int unsigned CNT_W = 16
);
    logic             start;
    logic             dir;
    logic [DIV_W-1:0] step_period;
    logic [CNT_W-1:0] step_count;
    logic             abort;
    logic             Encoder_SignalA;
    logic             Encoder_SignalB;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] position;

    modport master (
        output start, dir, step_period, step_count, abort,
        input  Encoder_SignalA, Encoder_SignalB, busy, done, position
    );

    modport slave (
        input  start, dir, step_period, step_count, abort,
        output Encoder_SignalA, Encoder_SignalB, busy, done, position
    );
endinterface

// File: rtl/quad_encoder_emulator_step_timer.sv
// Down-counting edge-spacing timer: one-cycle tick at zero, then reloads
// itself with the value captured on the last load.
module step_timer #(
    parameter int unsigned DIV_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [DIV_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             tick_c
);
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] reload_q, reload_d;

    assign tick_c = en_i && (cnt_q == '0);

    always_comb begin
        cnt_d    = cnt_q;
        reload_d = reload_q;
        if (load_i) begin
            cnt_d    = load_val_i;
            reload_d = load_val_i;
        end else if (en_i) begin
            cnt_d = (cnt_q == '0) ? reload_q : cnt_q - DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            reload_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
        end
    end
endmodule

// File: rtl/quad_encoder_emulator.sv
// Quadrature A/B generator: emits a commanded number of x4 edges in either
// direction at a programmable spacing and tracks the resulting position.
module quad_encoder_emulator
    import quad_pkg::*;
#(
    parameter int unsigned DIV_W = 24,
    parameter int unsigned CNT_W = 16
) (
    input logic                    clk,
    input logic                    reset,
    quad_encoder_emulator_if.slave bus
);
    logic [1:0]       state_q, state_d;
    logic [1:0]       phase_q, phase_d;
    logic [1:0]       ab_q, ab_d;
    logic [CNT_W-1:0] pos_q, pos_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             dir_q, dir_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [DIV_W-1:0] peff_c;
    logic             timer_load_c;
    logic             timer_en_c;
    logic             tick_c;

    // Spacing below two cycles is clamped so every phase is held at least twice
    assign peff_c = (bus.step_period < DIV_W'(MIN_PERIOD)) ? DIV_W'(MIN_PERIOD)
                                                           : bus.step_period;
    assign timer_load_c = (state_q == ST_IDLE) && bus.start && (bus.step_count != '0);
    assign timer_en_c   = (state_q == ST_RUN) && !bus.abort;

    step_timer #(.DIV_W(DIV_W)) u_step_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (timer_load_c),
        .load_val_i (peff_c - DIV_W'(1)),
        .en_i       (timer_en_c),
        .tick_c     (tick_c)
    );

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        pos_d   = pos_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    dir_d = bus.dir;
                    rem_d = bus.step_count;
                    if (bus.step_count == '0) begin
                        state_d = ST_FIN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        busy_d  = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                // Abort wins over a coincident expiry: no edge, no done
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else begin
                    busy_d = 1'b1;
                    if (tick_c) begin
                        phase_d = dir_q ? phase_q - 2'd1 : phase_q + 2'd1;
                        pos_d   = dir_q ? pos_q - CNT_W'(1) : pos_q + CNT_W'(1);
                        rem_d   = rem_q - CNT_W'(1);
                        if (rem_q == CNT_W'(1)) begin
                            state_d = ST_FIN;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ab_d = phase_to_ab(phase_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            phase_q <= 2'd0;
            ab_q    <= QPH_00;
            pos_q   <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            ab_q    <= ab_d;
            pos_q   <= pos_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.Encoder_SignalA = ab_q[1];
    assign bus.Encoder_SignalB = ab_q[0];
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.position        = pos_q;
endmodule

// File: tb/tb_quad_encoder_emulator.sv
// Scoreboard bench: each move pushes its expected edges/done pulse with
// their cycle stamps; a negedge monitor pops and compares as they appear.
module tb_quad_encoder_emulator;
    localparam int unsigned DIV_W = 24;
    localparam int unsigned CNT_W = 16;

    typedef struct {
        bit         is_done;
        logic [1:0] ab;
        logic [15:0] pos;
        bit         fwd;
        int         cyc;
    } ev_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   done_cnt = 0;
    int   busy_cyc = 0;
    bit   mon_en = 1'b1;
    logic [1:0]  m_phase = 2'd0;
    logic [15:0] m_pos = 16'd0;
    ev_t  sb[$];

    quad_encoder_emulator_if #(.DIV_W(DIV_W), .CNT_W(CNT_W)) bus ();

    quad_encoder_emulator #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Monitor: every AB change and every done pulse must match the queue head
    initial begin : monitor
        logic [1:0] prev_ab = 2'b00;
        logic [1:0] cur_ab;
        ev_t e;
        forever begin
            @(negedge clk);
            cur_ab = {bus.Encoder_SignalA, bus.Encoder_SignalB};
            if (!reset && mon_en) begin
                if (cur_ab != prev_ab) begin
                    chk("edge_expected", 32'(sb.size() != 0), 1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("edge_kind", 32'(e.is_done), 0);
                        chk("edge_ab", 32'(cur_ab), 32'(e.ab));
                        chk("edge_pos", 32'(bus.position), 32'(e.pos));
                        chk("edge_cyc", 32'(cyc), 32'(e.cyc));
                        chk("decoded_fwd", 32'(prev_ab[1] ^ cur_ab[0]), 32'(e.fwd));
                    end
                end
                if (bus.done) begin
                    chk("done_expected", 32'(sb.size() != 0), 1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("done_kind", 32'(e.is_done), 1);
                        chk("done_cyc", 32'(cyc), 32'(e.cyc));
                    end
                end
            end
            prev_ab = cur_ab;
            if (bus.busy) busy_cyc++;
            if (bus.done) done_cnt++;
        end
    end

    task automatic launch(input logic d, input int per, input int cnt, input int n_emit,
                          input bit exp_done, input bit with_abort, output int t0);
        int  peff;
        ev_t e;
        @(posedge clk); #1;
        bus.start       = 1'b1;
        bus.dir         = d;
        bus.step_period = 24'(per);
        bus.step_count  = 16'(cnt);
        bus.abort       = with_abort;
        t0   = cyc + 1;
        peff = (per < 2) ? 2 : per;
        for (int k = 1; k <= n_emit; k++) begin
            m_phase   = d ? m_phase - 2'd1 : m_phase + 2'd1;
            m_pos     = d ? m_pos - 16'd1 : m_pos + 16'd1;
            e.is_done = 1'b0;
            e.ab      = {m_phase[1], m_phase[1] ^ m_phase[0]};
            e.pos     = m_pos;
            e.fwd     = !d;
            e.cyc     = t0 + k * peff;
            sb.push_back(e);
        end
        if (exp_done) begin
            e.is_done = 1'b1;
            e.cyc     = t0 + cnt * peff;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        // Scramble the command inputs to show they are not re-sampled mid-move
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.dir         = ~d;
        bus.step_period = 24'($urandom);
        bus.step_count  = 16'($urandom);
    endtask

    task automatic wait_done(input int limit);
        bit ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk); #1;
            if (sb.size() == 0 && !bus.busy && !bus.done) begin
                ok = 1'b1;
                break;
            end
        end
        chk("move_complete", 32'(ok), 1);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin : stim
        int t0;
        int snap;
        reset = 1'b1;
        bus.start = 1'b0; bus.dir = 1'b0; bus.abort = 1'b0;
        bus.step_period = '0; bus.step_count = '0;
        @(posedge clk); #1;
        chk("rst_A", 32'(bus.Encoder_SignalA), 0);
        chk("rst_B", 32'(bus.Encoder_SignalB), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_pos", 32'(bus.position), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Forward 4 edges at spacing 3
        busy_cyc = 0; snap = done_cnt;
        launch(1'b0, 3, 4, 4, 1'b1, 1'b0, t0);
        wait_done(40);
        chk("fwd_busy_cycles", 32'(busy_cyc), 12);
        chk("fwd_done_count", 32'(done_cnt - snap), 1);
        chk("fwd_pos", 32'(bus.position), 32'h0004);

        // Reverse 3 edges at spacing 5
        snap = done_cnt;
        launch(1'b1, 5, 3, 3, 1'b1, 1'b0, t0);
        wait_done(40);
        chk("rev_done_count", 32'(done_cnt - snap), 1);
        chk("rev_pos", 32'(bus.position), 32'h0001);
        chk("rev_ab", 32'({bus.Encoder_SignalA, bus.Encoder_SignalB}), 32'b01);

        // Abort coincident with the 3rd expiry
        snap = done_cnt;
        launch(1'b0, 10, 8, 2, 1'b0, 1'b0, t0);
        wait_until(t0 + 29);
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_ab", 32'({bus.Encoder_SignalA, bus.Encoder_SignalB}), 32'b10);
        repeat (25) @(posedge clk);
        #1;
        chk("abort_ab_held", 32'({bus.Encoder_SignalA, bus.Encoder_SignalB}), 32'b10);
        chk("abort_pos_held", 32'(bus.position), 32'(m_pos));
        chk("abort_no_done", 32'(done_cnt - snap), 0);
        chk("abort_sb_empty", 32'(sb.size()), 0);

        // Zero count: done only
        snap = done_cnt;
        launch(1'b0, 3, 0, 0, 1'b1, 1'b0, t0);
        wait_done(10);
        chk("zero_done_count", 32'(done_cnt - snap), 1);

        // Spacing clamps to 2
        launch(1'b0, 0, 3, 3, 1'b1, 1'b0, t0);
        wait_done(20);
        launch(1'b1, 1, 3, 3, 1'b1, 1'b0, t0);
        wait_done(20);
        chk("clamp_pos", 32'(bus.position), 32'(m_pos));

        // Start pulsed mid-move is ignored
        snap = done_cnt;
        launch(1'b0, 4, 5, 5, 1'b1, 1'b0, t0);
        wait_until(t0 + 9);
        bus.start = 1'b1; bus.dir = 1'b1; bus.step_period = 24'd7; bus.step_count = 16'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(40);
        chk("midstart_done_count", 32'(done_cnt - snap), 1);
        chk("midstart_pos", 32'(bus.position), 32'(m_pos));

        // Start and abort together in IDLE: start wins
        launch(1'b1, 3, 2, 2, 1'b1, 1'b1, t0);
        wait_done(20);
        chk("start_abort_pos", 32'(bus.position), 32'(m_pos));

        // Reset in the middle of a move
        launch(1'b0, 4, 6, 6, 1'b1, 1'b0, t0);
        wait_until(t0 + 9);
        mon_en = 1'b0;
        reset  = 1'b1;
        @(posedge clk); #1;
        chk("midrst_A", 32'(bus.Encoder_SignalA), 0);
        chk("midrst_B", 32'(bus.Encoder_SignalB), 0);
        chk("midrst_busy", 32'(bus.busy), 0);
        chk("midrst_done", 32'(bus.done), 0);
        chk("midrst_pos", 32'(bus.position), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
        m_phase = 2'd0;
        m_pos   = 16'd0;
        snap = done_cnt;
        repeat (30) @(posedge clk);
        #1;
        chk("midrst_no_done", 32'(done_cnt - snap), 0);
        chk("midrst_busy_after", 32'(bus.busy), 0);
        mon_en = 1'b1;

        // Reverse wrap below zero, then back
        launch(1'b1, 2, 1, 1, 1'b1, 1'b0, t0);
        wait_done(10);
        chk("rev_wrap_pos", 32'(bus.position), 32'h0000_FFFF);
        launch(1'b0, 2, 1, 1, 1'b1, 1'b0, t0);
        wait_done(10);

        // Forward wrap across 0x7FFF
        launch(1'b0, 0, 16'h7FFE, 16'h7FFE, 1'b1, 1'b0, t0);
        wait_done(70000);
        chk("preload_pos", 32'(bus.position), 32'h0000_7FFE);
        launch(1'b0, 2, 3, 3, 1'b1, 1'b0, t0);
        wait_done(20);
        chk("fwd_wrap_pos", 32'(bus.position), 32'h0000_8001);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
